// File: rtl/axi_r_buf_pkg.sv
// Shared types and helpers for the AXI R-channel burst buffer.
package axi_r_buf_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    CUT_THROUGH = 1'b0,
    STORE_FWD   = 1'b1
  } mode_e;

  // Packed R beat width: id + user + data + resp(2) + last(1).
  function automatic int unsigned r_payload_width(int unsigned id, int unsigned data,
                                                  int unsigned user);
    return id + user + data + 3;
  endfunction

endpackage

// File: rtl/axi_r_buf_fifo.sv
// Generic circular storage array with read/write pointers, fill counter and a
// registered not-full flag. DEPTH must be a power of two so pointers wrap naturally.
module axi_r_buf_fifo
  import axi_r_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LVL_W-1:0] fill_o,
  output logic             not_full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] fill_q, fill_d;
  logic             not_full_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fill_d = fill_q;
    if (push_i) wptr_d = wptr_q + 1'b1;
    if (pop_i)  rptr_d = rptr_q + 1'b1;
    if (push_i && !pop_i)      fill_d = fill_q + 1'b1;
    else if (!push_i && pop_i) fill_d = fill_q - 1'b1;
  end

  // Not-full is computed from next-state fill so the flag is a flop with no
  // combinational path back from the pop side.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fill_q     <= '0;
      not_full_q <= 1'b1;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fill_q     <= fill_d;
      not_full_q <= (fill_d != LVL_W'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o    = mem_q[rptr_q];
  assign fill_o     = fill_q;
  assign not_full_o = not_full_q;

endmodule

// File: rtl/axi_r_burst_buffer.sv
// AXI R-channel burst buffer: cut-through or store-and-forward release over a circular FIFO.
// Optional beat/error statistics outputs are built when AXI_R_BUFFER_STATS_EN is defined.
module axi_r_burst_buffer
  import axi_r_buf_pkg::*;
#(
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned USER_WIDTH   = 6,
  parameter int unsigned BUFFER_DEPTH = 8,
  parameter int unsigned AF_THRESHOLD = 6,
  parameter int unsigned LVL_W        = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_en_i,
  input  logic                  saf_mode_i,
  input  logic                  slave_valid_i,
  output logic                  slave_ready_o,
  input  logic [DATA_WIDTH-1:0] slave_data_i,
  input  logic [1:0]            slave_resp_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  input  logic [ID_WIDTH-1:0]   slave_id_i,
  input  logic                  slave_last_i,
  output logic                  master_valid_o,
  input  logic                  master_ready_i,
  output logic [DATA_WIDTH-1:0] master_data_o,
  output logic [1:0]            master_resp_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  output logic [ID_WIDTH-1:0]   master_id_o,
  output logic                  master_last_o,
  output logic [LVL_W-1:0]      fill_level_o,
  output logic                  almost_full_o,
  output logic [LVL_W-1:0]      bursts_held_o
`ifdef AXI_R_BUFFER_STATS_EN
  ,
  output logic [31:0]           beat_cnt_o,
  output logic [15:0]           err_cnt_o
`endif
);

  localparam int unsigned PW = r_payload_width(ID_WIDTH, DATA_WIDTH, USER_WIDTH);

  logic [PW-1:0]    wdata, rdata;
  logic [LVL_W-1:0] fill;
  logic             push, pop, head_avail;
  logic [LVL_W-1:0] bursts_q, bursts_d;
  logic             unused_test_en;

  assign unused_test_en = test_en_i;

  assign push  = slave_valid_i && slave_ready_o;
  assign pop   = master_valid_o && master_ready_i;
  assign wdata = {slave_last_i, slave_resp_i, slave_data_i, slave_user_i, slave_id_i};

  axi_r_buf_fifo #(
    .WIDTH (PW),
    .DEPTH (BUFFER_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .pop_i      (pop),
    .wdata_i    (wdata),
    .rdata_o    (rdata),
    .fill_o     (fill),
    .not_full_o (slave_ready_o)
  );

  assign {master_last_o, master_resp_o, master_data_o, master_user_o, master_id_o} = rdata;

  // A full buffer with no complete burst is released anyway, otherwise a burst
  // longer than the depth would never drain.
  always_comb begin
    head_avail = (fill != '0);
    if (mode_e'(saf_mode_i) == STORE_FWD)
      master_valid_o = head_avail && ((bursts_q != '0) || (fill == LVL_W'(BUFFER_DEPTH)));
    else
      master_valid_o = head_avail;
  end

  always_comb begin
    bursts_d = bursts_q;
    if (push && slave_last_i && !(pop && master_last_o)) begin
      if (bursts_q != LVL_W'(BUFFER_DEPTH)) bursts_d = bursts_q + 1'b1;
    end else if (pop && master_last_o && !(push && slave_last_i)) begin
      if (bursts_q != '0) bursts_d = bursts_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bursts_q <= '0;
    else         bursts_q <= bursts_d;
  end

  assign fill_level_o  = fill;
  assign almost_full_o = (fill >= LVL_W'(AF_THRESHOLD));
  assign bursts_held_o = bursts_q;

`ifdef AXI_R_BUFFER_STATS_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (pop) begin
      beat_cnt_d = beat_cnt_q + 32'd1;
      if (resp_e'(master_resp_o) inside {SLVERR, DECERR}) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign beat_cnt_o = beat_cnt_q;
  assign err_cnt_o  = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi_r_burst_buffer.sv
// Directed self-checking bench for axi_r_burst_buffer (default depth 8, threshold 6).
module tb_axi_r_burst_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        test_en = 1'b0;
  logic        saf = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic [1:0]  s_resp = '0;
  logic [5:0]  s_user = '0;
  logic [3:0]  s_id = '0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic [1:0]  m_resp;
  logic [5:0]  m_user;
  logic [3:0]  m_id;
  logic        m_last;
  logic [3:0]  fill;
  logic        af;
  logic [3:0]  bursts;
`ifdef AXI_R_BUFFER_STATS_EN
  logic [31:0] beat_cnt;
  logic [15:0] err_cnt;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int exp_fill [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8};
  logic [1:0] st_resp [5] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b01};

  always #5 clk = ~clk;

  axi_r_burst_buffer u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .test_en_i      (test_en),
    .saf_mode_i     (saf),
    .slave_valid_i  (s_valid),
    .slave_ready_o  (s_ready),
    .slave_data_i   (s_data),
    .slave_resp_i   (s_resp),
    .slave_user_i   (s_user),
    .slave_id_i     (s_id),
    .slave_last_i   (s_last),
    .master_valid_o (m_valid),
    .master_ready_i (m_ready),
    .master_data_o  (m_data),
    .master_resp_o  (m_resp),
    .master_user_o  (m_user),
    .master_id_o    (m_id),
    .master_last_o  (m_last),
    .fill_level_o   (fill),
    .almost_full_o  (af),
    .bursts_held_o  (bursts)
`ifdef AXI_R_BUFFER_STATS_EN
    ,
    .beat_cnt_o     (beat_cnt),
    .err_cnt_o      (err_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic put(input logic v, input logic [63:0] d, input logic l,
                     input logic [1:0] r, input logic [3:0] id);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    s_resp  = r;
    s_id    = id;
    s_user  = d[5:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    check("rst_mvalid", m_valid, 0);
    check("rst_fill", fill, 0);
    check("rst_bursts", bursts, 0);
    check("rst_af", af, 0);
`ifdef AXI_R_BUFFER_STATS_EN
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("rel_sready", s_ready, 1);

    // cut-through, 3 beats streaming through with interleaved IDs
    saf = 1'b0;
    m_ready = 1'b1;
    put(1, 64'hA0, 0, 2'b00, 4'h1);
    #1 check("ct_no_fallthru", m_valid, 0);
    tick();
    check("ct_b0_valid", m_valid, 1);
    check("ct_b0_data", m_data, 64'hA0);
    check("ct_b0_id", m_id, 4'h1);
    check("ct_b0_user", m_user, 6'h20);
    check("ct_b0_fill", fill, 1);
    put(1, 64'hA1, 1, 2'b00, 4'h2);
    tick();
    check("ct_b1_data", m_data, 64'hA1);
    check("ct_b1_id", m_id, 4'h2);
    check("ct_b1_last", m_last, 1);
    check("ct_b1_fill", fill, 1);
    put(1, 64'hA2, 1, 2'b10, 4'h1);
    tick();
    check("ct_b2_data", m_data, 64'hA2);
    check("ct_b2_resp", m_resp, 2'b10);
    check("ct_b2_fill", fill, 1);
    check("ct_b2_bursts", bursts, 1);
    put(0, 64'h0, 0, 2'b00, 4'h0);
    tick();
    check("ct_end_fill", fill, 0);
    check("ct_end_valid", m_valid, 0);
    check("ct_end_bursts", bursts, 0);

    // store-and-forward, one 4-beat burst
    saf = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(1, 64'hB0 + 64'(i), (i == 3), 2'b00, 4'h3);
      tick();
      if (i < 3) begin
        check("saf_hold_valid", m_valid, 0);
        check("saf_hold_bursts", bursts, 0);
        check("saf_hold_fill", fill, i + 1);
      end
    end
    check("saf_rel_valid", m_valid, 1);
    check("saf_rel_bursts", bursts, 1);
    check("saf_rel_fill", fill, 4);
    check("saf_rel_data", m_data, 64'hB0);
    put(0, 64'h0, 0, 2'b00, 4'h0);
    for (int j = 0; j < 4; j++) begin
      tick();
      check("saf_pop_fill", fill, 3 - j);
      if (j < 3) begin
        check("saf_pop_valid", m_valid, 1);
        check("saf_pop_data", m_data, 64'hB1 + 64'(j));
        check("saf_pop_bursts", bursts, 1);
      end
    end
    check("saf_end_valid", m_valid, 0);
    check("saf_end_bursts", bursts, 0);

    // overflow: 10-beat burst into depth 8, sink stalled, full override releases
    m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      put(1, 64'hC0 + 64'((k < 8) ? k : 8), 0, 2'b00, 4'h4);
      tick();
      check("ovf_fill", fill, exp_fill[k]);
      check("ovf_af", af, (exp_fill[k] >= 6));
      check("ovf_sready", s_ready, (exp_fill[k] != 8));
      check("ovf_mvalid", m_valid, (exp_fill[k] == 8));
    end
    check("ovf_head", m_data, 64'hC0);
    m_ready = 1'b1;
    tick();
    check("ovf_pop_fill", fill, 7);
    check("ovf_pop_mvalid", m_valid, 0);
    check("ovf_pop_sready", s_ready, 1);
    tick();
    check("ovf_refill_fill", fill, 8);
    check("ovf_refill_data", m_data, 64'hC1);
    check("ovf_refill_sready", s_ready, 0);
    put(1, 64'hC9, 1, 2'b00, 4'h4);
    tick();
    check("ovf_pop2_fill", fill, 7);
    tick();
    check("ovf_last_fill", fill, 8);
    check("ovf_last_bursts", bursts, 1);
    check("ovf_last_data", m_data, 64'hC2);
    put(0, 64'h0, 0, 2'b00, 4'h0);
    for (int j = 0; j < 8; j++) begin
      tick();
      check("ovf_drain_fill", fill, 7 - j);
      if (j < 7) check("ovf_drain_data", m_data, 64'hC3 + 64'(j));
    end
    check("ovf_end_valid", m_valid, 0);
    check("ovf_end_bursts", bursts, 0);

    // simultaneous push+pop at fill 5, write pointer crossing entry 7 -> 0
    saf = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(1, 64'hD0 + 64'(i), (i == 0) || (i == 4), 2'b00, 4'h5);
      tick();
    end
    check("pp_pre_fill", fill, 5);
    check("pp_pre_bursts", bursts, 2);
    check("pp_pre_data", m_data, 64'hD0);
    m_ready = 1'b1;
    put(1, 64'hD5, 1, 2'b00, 4'h5);
    tick();
    check("pp_last_fill", fill, 5);
    check("pp_last_bursts", bursts, 2);
    check("pp_last_data", m_data, 64'hD1);
    put(1, 64'hD6, 0, 2'b00, 4'h5);
    tick();
    check("pp_w7_fill", fill, 5);
    check("pp_w7_data", m_data, 64'hD2);
    put(1, 64'hD7, 0, 2'b00, 4'h5);
    tick();
    check("pp_w0_fill", fill, 5);
    check("pp_w0_bursts", bursts, 2);
    put(0, 64'h0, 0, 2'b00, 4'h0);
    for (int j = 0; j < 5; j++) begin
      tick();
      check("pp_drain_fill", fill, 4 - j);
      if (j < 4) check("pp_drain_data", m_data, 64'hD4 + 64'(j));
    end
    check("pp_end_bursts", bursts, 0);

    // asynchronous reset mid-burst at fill 3
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(1, 64'hE0 + 64'(i), (i == 0), 2'b00, 4'h6);
      tick();
    end
    check("ar_pre_fill", fill, 3);
    check("ar_pre_mvalid", m_valid, 1);
    check("ar_pre_bursts", bursts, 1);
    put(0, 64'h0, 0, 2'b00, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_mvalid", m_valid, 0);
    check("ar_fill", fill, 0);
    check("ar_bursts", bursts, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check("ar_rel_sready", s_ready, 1);
    check("ar_rel_fill", fill, 0);

`ifdef AXI_R_BUFFER_STATS_EN
    // statistics: 5 pops, two SLVERR
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put(1, 64'h50 + 64'(i), (i == 4), st_resp[i], 4'h7);
      tick();
    end
    put(0, 64'h0, 0, 2'b00, 4'h0);
    tick();
    check("st_beat_cnt", beat_cnt, 5);
    check("st_err_cnt", err_cnt, 2);
`endif

    // buffer usable after reset, no stale contents
    m_ready = 1'b0;
    put(1, 64'hF0, 1, 2'b00, 4'h8);
    tick();
    check("post_rst_data", m_data, 64'hF0);
    check("post_rst_fill", fill, 1);
    put(0, 64'h0, 0, 2'b00, 4'h0);
    m_ready = 1'b1;
    tick();
    check("post_rst_empty", fill, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
